execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 130 +++++++++++++
 tb/tb_execute_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage for a 4 x 8-bit register file: single-cycle ALU ops write back
// the cycle after acceptance; MUL runs an 8-step shift-add before its write-back.
module execute_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] opcode,
  input  logic [1:0] dest_reg,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic [7:0] write_data,
  output logic [1:0] write_reg,
  output logic       write_reg_en,
  output logic [2:0] czn,
  output logic       busy
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_MUL = 3'd6, OP_NOP = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

  state_t      state_q, state_d;
  logic [7:0]  write_data_q, write_data_d;
  logic [1:0]  write_reg_q, write_reg_d;
  logic [2:0]  czn_q, czn_d;
  logic [1:0]  dest_q, dest_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [8:0]  alu_full;
  logic [7:0]  alu_res;
  logic        alu_c;
  logic        accept;

  assign op_ready     = (state_q != S_MUL);
  assign busy         = (state_q == S_MUL);
  assign write_reg_en = (state_q == S_WB);
  assign write_data   = write_data_q;
  assign write_reg    = write_reg_q;
  assign czn          = czn_q;
  assign accept       = op_valid && op_ready;

  // Bit 8 of the 9-bit add/sub is carry-out for ADD and borrow for SUB.
  always_comb begin
    alu_full = 9'd0;
    alu_c    = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_full = {1'b0, operand_a} + {1'b0, operand_b}; alu_c = alu_full[8]; end
      OP_SUB:  begin alu_full = {1'b0, operand_a} - {1'b0, operand_b}; alu_c = alu_full[8]; end
      OP_AND:  alu_full = {1'b0, operand_a & operand_b};
      OP_OR:   alu_full = {1'b0, operand_a | operand_b};
      OP_XOR:  alu_full = {1'b0, operand_a ^ operand_b};
      OP_SHL:  begin alu_full = {1'b0, operand_a[6:0], 1'b0}; alu_c = operand_a[7]; end
      default: alu_full = 9'd0;
    endcase
    alu_res = alu_full[7:0];
  end

  always_comb begin
    state_d      = state_q;
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    czn_d        = czn_q;
    dest_d       = dest_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    if (state_q == S_MUL) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : 16'd0);
      mcand_d  = {mcand_q[14:0], 1'b0};
      mplier_d = {1'b0, mplier_q[7:1]};
      cnt_d    = cnt_q + 4'd1;
      if (cnt_q == 4'd7) begin
        state_d      = S_WB;
        write_data_d = acc_d[7:0];
        write_reg_d  = dest_q;
        czn_d        = {acc_d[7], (acc_d[7:0] == 8'd0), (acc_d[15:8] != 8'd0)};
      end
    end else begin
      state_d = S_IDLE;
      if (accept) begin
        case (opcode)
          OP_NOP: state_d = S_IDLE;
          OP_MUL: begin
            state_d  = S_MUL;
            dest_d   = dest_reg;
            acc_d    = 16'd0;
            mcand_d  = {8'd0, operand_a};
            mplier_d = operand_b;
            cnt_d    = 4'd0;
          end
          default: begin
            state_d      = S_WB;
            write_data_d = alu_res;
            write_reg_d  = dest_reg;
            czn_d        = {alu_res[7], (alu_res == 8'd0), alu_c};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      write_data_q <= 8'd0;
      write_reg_q  <= 2'd0;
      czn_q        <= 3'd0;
      dest_q       <= 2'd0;
      acc_q        <= 16'd0;
      mcand_q      <= 16'd0;
      mplier_q     <= 8'd0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      czn_q        <= czn_d;
      dest_q       <= dest_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: vector table plus directed MUL/NOP/reset sequences;
// expected write-backs are queued at acceptance and matched against the write port.
module tb_execute_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid, op_ready;
  logic [2:0] opcode;
  logic [1:0] dest_reg;
  logic [7:0] operand_a, operand_b;
  logic [7:0] write_data;
  logic [1:0] write_reg;
  logic       write_reg_en;
  logic [2:0] czn;
  logic       busy;

  execute_stage dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .dest_reg(dest_reg), .operand_a(operand_a), .operand_b(operand_b),
    .write_data(write_data), .write_reg(write_reg), .write_reg_en(write_reg_en),
    .czn(czn), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] d;
    logic [7:0] res;
    logic [2:0] f;
  } vec_t;

  typedef struct {
    int         due;
    logic [1:0] r;
    logic [7:0] d;
    logic [2:0] f;
  } exp_t;

  exp_t q[$];
  vec_t tbl[13];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Write-port monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (write_reg_en === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_write", 32'(write_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(e.due));
          chk("wb_reg", 32'(write_reg), 32'(e.r));
          chk("wb_data", 32'(write_data), 32'(e.d));
          chk("wb_czn", 32'(czn), 32'(e.f));
        end
      end else if (q.size() > 0 && q[0].due < cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("missed_write", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called just after a negedge; returns just after the following negedge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] d, input logic [7:0] res, input logic [2:0] f);
    int   waited = 0;
    exp_t e;
    while (op_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (op_ready !== 1'b1) chk("ready_timeout", 32'(op_ready), 32'd1);
    op_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; dest_reg = d;
    @(posedge clk);
    #1;
    if (op != 3'd7) begin
      e.due = cyc + ((op == 3'd6) ? 8 : 0);
      e.r = d; e.d = res; e.f = f;
      q.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // czn is {N,Z,C}
    tbl[0]  = '{3'd0, 8'hF0, 8'h20, 2'd2, 8'h10, 3'b001};
    tbl[1]  = '{3'd1, 8'h05, 8'h05, 2'd1, 8'h00, 3'b010};
    tbl[2]  = '{3'd1, 8'h03, 8'h05, 2'd3, 8'hFE, 3'b101};
    tbl[3]  = '{3'd2, 8'hF0, 8'h0F, 2'd0, 8'h00, 3'b010};
    tbl[4]  = '{3'd3, 8'h80, 8'h01, 2'd1, 8'h81, 3'b100};
    tbl[5]  = '{3'd4, 8'hFF, 8'h0F, 2'd2, 8'hF0, 3'b100};
    tbl[6]  = '{3'd5, 8'h80, 8'h00, 2'd3, 8'h00, 3'b011};
    tbl[7]  = '{3'd5, 8'h41, 8'h00, 2'd0, 8'h82, 3'b100};
    tbl[8]  = '{3'd0, 8'h7F, 8'h01, 2'd1, 8'h80, 3'b100};
    tbl[9]  = '{3'd6, 8'h0F, 8'h0F, 2'd2, 8'hE1, 3'b100};
    tbl[10] = '{3'd6, 8'hFF, 8'hFF, 2'd3, 8'h01, 3'b001};
    tbl[11] = '{3'd0, 8'hFF, 8'h01, 2'd0, 8'h00, 3'b011};
    tbl[12] = '{3'd4, 8'h3C, 8'h3C, 2'd2, 8'h00, 3'b010};

    rst = 1'b0; op_valid = 1'b0; opcode = 3'd7; dest_reg = 2'd0;
    operand_a = 8'd0; operand_b = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write_data", 32'(write_data), 32'h0);
    chk("rst_write_reg", 32'(write_reg), 32'h0);
    chk("rst_write_en", 32'(write_reg_en), 32'h0);
    chk("rst_czn", 32'(czn), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_op_ready", 32'(op_ready), 32'h1);

    // First edge after reset release must accept.
    rst = 1'b1;
    issue(3'd0, 8'hF0, 8'h20, 2'd2, 8'h10, 3'b001);

    // Table vectors, back-to-back where the stage allows it.
    for (int i = 0; i < 13; i++)
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].res, tbl[i].f);
    repeat (3) @(negedge clk);
    chk("table_drained", 32'(q.size()), 32'd0);

    // MUL with an ADD offered throughout the busy window.
    issue(3'd6, 8'h10, 8'h11, 2'd1, 8'h10, 3'b001);
    for (int i = 0; i < 8; i++) begin
      op_valid = 1'b1; opcode = 3'd0; operand_a = 8'h01; operand_b = 8'h01; dest_reg = 2'd3;
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_not_ready", 32'(op_ready), 32'd0);
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("mul_wb_not_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("mul_drained", 32'(q.size()), 32'd0);

    // NOP after an AND leaves flags and writes nothing.
    issue(3'd2, 8'hF0, 8'h0F, 2'd3, 8'h00, 3'b010);
    issue(3'd7, 8'h12, 8'h34, 2'd1, 8'h00, 3'b000);
    repeat (2) @(negedge clk);
    chk("nop_czn", 32'(czn), 32'b010);
    chk("nop_ready", 32'(op_ready), 32'd1);
    chk("nop_drained", 32'(q.size()), 32'd0);

    // Reset in the fourth MUL cycle aborts the multiply.
    issue(3'd6, 8'h0F, 8'h0F, 2'd0, 8'hE1, 3'b100);
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    q.delete();
    chk("abort_write_data", 32'(write_data), 32'h0);
    chk("abort_write_reg", 32'(write_reg), 32'h0);
    chk("abort_czn", 32'(czn), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_op_ready", 32'(op_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_czn_held", 32'(czn), 32'h0);
    chk("abort_write_data_held", 32'(write_data), 32'h0);

    // Back-to-back SUB pair after the abort.
    issue(3'd1, 8'h05, 8'h05, 2'd0, 8'h00, 3'b010);
    issue(3'd1, 8'h03, 8'h05, 2'd1, 8'hFE, 3'b101);
    repeat (3) @(negedge clk);
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
